// File: rtl/btb_upd_arb_if.sv
// Bundle between fetch1/retire producers, the update arbiter and the BTB way.
// BTB_UPD_PERF_EN adds the two performance counter outputs.
interface btb_upd_arb_if #(
  parameter int RT_DEPTH = 4
);
  localparam int CW = $clog2(RT_DEPTH) + 1;

  logic          sp_valid_i;
  logic [2:0]    sp_brpos_i;
  logic [1:0]    sp_brtyp_i;
  logic [63:0]   sp_brpc_i;
  logic [63:0]   sp_brtar_i;
  logic [1:0]    sp_rasctl_i;
  logic          rt_valid_i;
  logic          rt_ready_o;
  logic          rt_brdir_i;
  logic [63:0]   rt_brpc_i;
  logic [63:0]   rt_taken_addr_i;
  logic          btb_sp_we_o;
  logic [2:0]    btb_sp_brpos_o;
  logic [1:0]    btb_sp_brtyp_o;
  logic [63:0]   btb_sp_brpc_o;
  logic [63:0]   btb_sp_brtar_o;
  logic [1:0]    btb_ras_ctl_o;
  logic          btb_rt_we_o;
  logic          btb_rt_brdir_o;
  logic [63:0]   btb_rt_brpc_o;
  logic [63:0]   btb_taken_addr_o;
  logic          sp_drop_o;
  logic [CW-1:0] rt_cnt_o;
`ifdef BTB_UPD_PERF_EN
  logic [31:0]   perf_sp_drop_o;
  logic [31:0]   perf_rt_stall_o;

  modport master (
    output sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
           rt_valid_i, rt_brdir_i, rt_brpc_i, rt_taken_addr_i,
    input  rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o,
           btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
           btb_taken_addr_o, sp_drop_o, rt_cnt_o, perf_sp_drop_o, perf_rt_stall_o
  );
  modport slave (
    input  sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
           rt_valid_i, rt_brdir_i, rt_brpc_i, rt_taken_addr_i,
    output rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o,
           btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
           btb_taken_addr_o, sp_drop_o, rt_cnt_o, perf_sp_drop_o, perf_rt_stall_o
  );
`else
  modport master (
    output sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
           rt_valid_i, rt_brdir_i, rt_brpc_i, rt_taken_addr_i,
    input  rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o,
           btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
           btb_taken_addr_o, sp_drop_o, rt_cnt_o
  );
  modport slave (
    input  sp_valid_i, sp_brpos_i, sp_brtyp_i, sp_brpc_i, sp_brtar_i, sp_rasctl_i,
           rt_valid_i, rt_brdir_i, rt_brpc_i, rt_taken_addr_i,
    output rt_ready_o, btb_sp_we_o, btb_sp_brpos_o, btb_sp_brtyp_o, btb_sp_brpc_o,
           btb_sp_brtar_o, btb_ras_ctl_o, btb_rt_we_o, btb_rt_brdir_o, btb_rt_brpc_o,
           btb_taken_addr_o, sp_drop_o, rt_cnt_o
  );
`endif
endinterface

// File: rtl/btb_upd_arb.sv
// BTB way write-port arbiter: queues retire updates and arbitrates them against
// fetch1 speculative allocates. BTB_UPD_PERF_EN enables drop/stall counters.
module btb_upd_arb #(
  parameter int RT_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input logic           clock,
  input logic           reset_n,
  btb_upd_arb_if.slave  bus
);
  localparam int AW = $clog2(RT_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        dir;
    logic [63:0] pc;
    logic [63:0] addr;
  } rt_ent_t;

  rt_ent_t       mem [RT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic          pend, starved, enq, sp_gnt, rt_gnt, drop;
  rt_ent_t       head, wr_ent;

  assign pend           = (count != '0);
  assign starved        = (starve == SW'(STARVE_MAX));
  assign bus.rt_ready_o = (count < (AW+1)'(RT_DEPTH));
  assign bus.rt_cnt_o   = count;
  assign enq            = bus.rt_valid_i && bus.rt_ready_o;
  assign head           = mem[rd_ptr];
  assign wr_ent         = '{dir: bus.rt_brdir_i, pc: bus.rt_brpc_i, addr: bus.rt_taken_addr_i};

  // Spec wins unless the queue has waited STARVE_MAX consecutive losses.
  always_comb begin
    sp_gnt = bus.sp_valid_i && (!pend || !starved);
    rt_gnt = pend && (!bus.sp_valid_i || starved);
    drop   = bus.sp_valid_i && pend && starved;
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (enq)    wr_ptr <= wr_ptr + 1'b1;
      if (rt_gnt) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, rt_gnt})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!pend || rt_gnt)       starve <= '0;
      else if (sp_gnt && !starved) starve <= starve + 1'b1;
    end
  end

  // Registered BTB drive; data fields only move with their strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.btb_sp_we_o      <= 1'b0;
      bus.btb_sp_brpos_o   <= '0;
      bus.btb_sp_brtyp_o   <= '0;
      bus.btb_sp_brpc_o    <= '0;
      bus.btb_sp_brtar_o   <= '0;
      bus.btb_ras_ctl_o    <= '0;
      bus.btb_rt_we_o      <= 1'b0;
      bus.btb_rt_brdir_o   <= 1'b0;
      bus.btb_rt_brpc_o    <= '0;
      bus.btb_taken_addr_o <= '0;
      bus.sp_drop_o        <= 1'b0;
    end else begin
      bus.btb_sp_we_o <= sp_gnt;
      bus.btb_rt_we_o <= rt_gnt;
      bus.sp_drop_o   <= drop;
      if (sp_gnt) begin
        bus.btb_sp_brpos_o <= bus.sp_brpos_i;
        bus.btb_sp_brtyp_o <= bus.sp_brtyp_i;
        bus.btb_sp_brpc_o  <= bus.sp_brpc_i;
        bus.btb_sp_brtar_o <= bus.sp_brtar_i;
        bus.btb_ras_ctl_o  <= bus.sp_rasctl_i;
      end
      if (rt_gnt) begin
        bus.btb_rt_brdir_o   <= head.dir;
        bus.btb_rt_brpc_o    <= head.pc;
        bus.btb_taken_addr_o <= head.addr;
      end
    end
  end

`ifdef BTB_UPD_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.perf_sp_drop_o  <= '0;
      bus.perf_rt_stall_o <= '0;
    end else begin
      if (drop && (bus.perf_sp_drop_o != '1))
        bus.perf_sp_drop_o <= bus.perf_sp_drop_o + 1'b1;
      if (bus.rt_valid_i && !bus.rt_ready_o && (bus.perf_rt_stall_o != '1))
        bus.perf_rt_stall_o <= bus.perf_rt_stall_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_upd_arb.sv
// Bench for btb_upd_arb: queue-based reference model checked every cycle,
// plus literal expectations along directed scenarios.
module tb_btb_upd_arb;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  btb_upd_arb_if #(.RT_DEPTH(DEPTH)) bus ();
  btb_upd_arb #(.RT_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  typedef struct {
    logic        dir;
    logic [63:0] pc;
    logic [63:0] addr;
  } upd_t;

  upd_t        q[$];
  int          starve = 0;
  int          nerr = 0, nchk = 0;
  logic        e_sp_we = 0, e_rt_we = 0, e_drop = 0, e_dir = 0;
  logic [2:0]  e_pos = 0;
  logic [1:0]  e_typ = 0, e_ras = 0;
  logic [63:0] e_spc = 0, e_tar = 0, e_rpc = 0, e_addr = 0;
  longint      e_pdrop = 0, e_pstall = 0;
  bit          chk_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    starve = 0;
    {e_sp_we, e_rt_we, e_drop, e_dir} = '0;
    {e_pos, e_typ, e_ras} = '0;
    {e_spc, e_tar, e_rpc, e_addr} = '0;
    e_pdrop = 0;
    e_pstall = 0;
  endtask

  // One clock of the arbitration rules, applied to the inputs seen at the edge.
  task automatic model_step();
    bit pend, ready, spg, rtg;
    upd_t h;
    if (!reset_n) return;
    pend  = q.size() > 0;
    ready = q.size() < DEPTH;
    spg   = bus.sp_valid_i && (!pend || starve < SMAX);
    rtg   = pend && !spg;
    e_drop = bus.sp_valid_i && rtg;
    if (e_drop) e_pdrop = (e_pdrop < 64'hFFFF_FFFF) ? e_pdrop + 1 : e_pdrop;
    if (bus.rt_valid_i && !ready) e_pstall++;
    e_sp_we = spg;
    e_rt_we = rtg;
    if (spg) begin
      e_pos = bus.sp_brpos_i; e_typ = bus.sp_brtyp_i; e_spc = bus.sp_brpc_i;
      e_tar = bus.sp_brtar_i; e_ras = bus.sp_rasctl_i;
    end
    if (rtg) begin
      h = q.pop_front();
      e_dir = h.dir; e_rpc = h.pc; e_addr = h.addr;
    end
    if (!pend || rtg) starve = 0;
    else if (spg) starve = starve + 1;
    if (bus.rt_valid_i && ready)
      q.push_back('{dir: bus.rt_brdir_i, pc: bus.rt_brpc_i, addr: bus.rt_taken_addr_i});
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("sp_we",    bus.btb_sp_we_o,      e_sp_we);
      chk("rt_we",    bus.btb_rt_we_o,      e_rt_we);
      chk("sp_drop",  bus.sp_drop_o,        e_drop);
      chk("sp_pos",   bus.btb_sp_brpos_o,   e_pos);
      chk("sp_typ",   bus.btb_sp_brtyp_o,   e_typ);
      chk("sp_pc",    bus.btb_sp_brpc_o,    e_spc);
      chk("sp_tar",   bus.btb_sp_brtar_o,   e_tar);
      chk("ras",      bus.btb_ras_ctl_o,    e_ras);
      chk("rt_dir",   bus.btb_rt_brdir_o,   e_dir);
      chk("rt_pc",    bus.btb_rt_brpc_o,    e_rpc);
      chk("rt_addr",  bus.btb_taken_addr_o, e_addr);
      chk("rt_cnt",   bus.rt_cnt_o,         q.size());
      chk("rt_ready", bus.rt_ready_o,       q.size() < DEPTH);
`ifdef BTB_UPD_PERF_EN
      chk("perf_drop",  bus.perf_sp_drop_o,  e_pdrop);
      chk("perf_stall", bus.perf_rt_stall_o, e_pstall);
`endif
    end
  end

  task automatic set_sp(input logic v, input logic [2:0] pos, input logic [1:0] typ,
                        input logic [63:0] pc, input logic [63:0] tar, input logic [1:0] ras);
    bus.sp_valid_i = v; bus.sp_brpos_i = pos; bus.sp_brtyp_i = typ;
    bus.sp_brpc_i = pc; bus.sp_brtar_i = tar; bus.sp_rasctl_i = ras;
  endtask

  task automatic set_rt(input logic v, input logic dir, input logic [63:0] pc, input logic [63:0] addr);
    bus.rt_valid_i = v; bus.rt_brdir_i = dir; bus.rt_brpc_i = pc; bus.rt_taken_addr_i = addr;
  endtask

  initial begin
    int nrt;
    set_sp(0, 0, 0, 0, 0, 0);
    set_rt(0, 0, 0, 0);
    model_clear();
    repeat (3) tick();
    @(negedge clock);
    chk("rst_ready", bus.rt_ready_o, 1);
    chk("rst_cnt",   bus.rt_cnt_o, 0);
    chk("rst_we",    {bus.btb_sp_we_o, bus.btb_rt_we_o}, 0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    tick();

    // Single retire with idle spec: strobe two cycles after the request.
    set_rt(1, 1, 64'h1000, 64'h1111);
    tick();
    set_rt(0, 0, 0, 0);
    tick();
    @(negedge clock);
    chk("single_we",  bus.btb_rt_we_o, 1);
    chk("single_pc",  bus.btb_rt_brpc_o, 64'h1000);
    chk("single_dir", bus.btb_rt_brdir_o, 1);
    chk("single_cnt", bus.rt_cnt_o, 0);
    tick();

    // Spec only.
    set_sp(1, 3'd5, 2'b01, 64'h2004, 64'h3000, 2'b10);
    tick();
    set_sp(0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk("spec_we",  bus.btb_sp_we_o, 1);
    chk("spec_pc",  bus.btb_sp_brpc_o, 64'h2004);
    chk("spec_typ", bus.btb_sp_brtyp_o, 2'b01);
    chk("spec_tar", bus.btb_sp_brtar_o, 64'h3000);
    chk("spec_rtwe", bus.btb_rt_we_o, 0);
    tick();

    // Starvation: 3 spec wins, then a forced retire with a drop.
    set_rt(1, 0, 64'h4000, 64'h4444);
    tick();
    set_rt(0, 0, 0, 0);
    set_sp(1, 3'd1, 2'b10, 64'h4100, 64'h4200, 2'b01);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clock);
      chk("starve_sp",   bus.btb_sp_we_o, (i != 3));
      chk("starve_rt",   bus.btb_rt_we_o, (i == 3));
      chk("starve_drop", bus.sp_drop_o,   (i == 3));
    end
    set_sp(0, 0, 0, 0, 0, 0);
    tick();

    // Full FIFO with spec busy; fifth request refused.
    set_sp(1, 3'd2, 2'b11, 64'h6000, 64'h6100, 2'b00);
    for (int i = 0; i < 5; i++) begin
      set_rt(1, i[0], 64'h5000 + 64'(4 * i), 64'h7000 + 64'(i));
      tick();
      if (i == 3) begin
        @(negedge clock);
        chk("full_ready", bus.rt_ready_o, 0);
        chk("full_cnt",   bus.rt_cnt_o, 4);
      end
    end
    @(negedge clock);
    chk("full_cnt5",  bus.rt_cnt_o, 3);
    chk("full_first", bus.btb_rt_brpc_o, 64'h5000);
    set_rt(0, 0, 0, 0);
    set_sp(0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      @(negedge clock);
      chk("drain_pc", bus.btb_rt_brpc_o, 64'h5000 + 64'(4 * i));
    end
    tick();
    @(negedge clock);
    chk("drain_cnt", bus.rt_cnt_o, 0);

    // Reset with three entries queued.
    set_sp(1, 3'd3, 2'b01, 64'h8000, 64'h8100, 2'b11);
    for (int i = 0; i < 3; i++) begin
      set_rt(1, 1, 64'h9000 + 64'(i), 64'h9900);
      tick();
    end
    set_rt(0, 0, 0, 0);
    set_sp(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_clear();
    #1;
    chk("mrst_cnt",   bus.rt_cnt_o, 0);
    chk("mrst_ready", bus.rt_ready_o, 1);
    chk("mrst_we",    {bus.btb_sp_we_o, bus.btb_rt_we_o}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    nrt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clock);
      nrt += int'(bus.btb_rt_we_o);
    end
    chk("mrst_stale", nrt, 0);

    // Mixed traffic exercising pointer wrap, stalls and repeated drops.
    for (int i = 0; i < 48; i++) begin
      set_sp((i % 3) != 0, 3'(i), 2'(i), 64'hA000 + 64'(i), 64'hB000 + 64'(i), 2'(i >> 1));
      set_rt((i % 2) == 0 || i > 30, 1'(i >> 2), 64'hC000 + 64'(i), 64'hD000 + 64'(i));
      tick();
    end
    set_sp(0, 0, 0, 0, 0, 0);
    set_rt(0, 0, 0, 0);
    repeat (6) tick();
    @(negedge clock);
    chk("final_cnt", bus.rt_cnt_o, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/btb_upd_arb.md
Name: btb_upd_arb

Overview:
- Write-port arbiter and update scheduler for one BTB way.
- The BTB way has a single effective write port, so a same-cycle retire update is silently lost when a fetch1 speculative allocate occurs.
- This block queues retire-stage counter/target updates in a small FIFO and arbitrates them against fetch1 speculative allocates.
- Drives the way's btb_sp_* / btb_rt_* inputs with registered, mutually exclusive write strobes; sits between fetch1/retire and the BTB way.

Parameters:
- RT_DEPTH, 4, retire update FIFO entries (power of two, >=2)
- STARVE_MAX, 3, consecutive spec wins over a non-empty FIFO before retire is forced

Ports:
- clock  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- sp_valid_i  input  1  fetch1 speculative allocate request (no backpressure)
- sp_brpos_i  input  3  branch position in bundle
- sp_brtyp_i  input  2  branch type
- sp_brpc_i  input  64  bundle PC
- sp_brtar_i  input  64  branch target
- sp_rasctl_i  input  2  RAS control
- rt_valid_i  input  1  retire update request
- rt_ready_o  output  1  FIFO can accept (count < RT_DEPTH)
- rt_brdir_i  input  1  resolved direction
- rt_brpc_i  input  64  retire bundle PC
- rt_taken_addr_i  input  64  resolved target
- btb_sp_we_o  output  1  to BTB speculative write enable
- btb_sp_brpos_o  output  3  to BTB
- btb_sp_brtyp_o  output  2  to BTB
- btb_sp_brpc_o  output  64  to BTB
- btb_sp_brtar_o  output  64  to BTB
- btb_ras_ctl_o  output  2  to BTB
- btb_rt_we_o  output  1  to BTB retire write enable
- btb_rt_brdir_o  output  1  to BTB
- btb_rt_brpc_o  output  64  to BTB
- btb_taken_addr_o  output  64  to BTB taken address
- sp_drop_o  output  1  one-cycle pulse: spec allocate discarded
- rt_cnt_o  output  $clog2(RT_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0 except rt_ready_o=1. FIFO empty, starve counter 0.
- Reset mid-operation discards queued updates; no write strobe is asserted while reset_n is low.
- Enqueue: rt_valid_i && rt_ready_o at edge t. Entry is visible at FIFO head from t+1. There is no empty-FIFO pass-through. Minimum retire latency is 2 cycles (request at t, btb_rt_we_o at t+2).
- Full FIFO:
  - rt_ready_o=0; rt_valid_i is ignored.
  - rt_ready_o depends on occupancy only. A dequeue in the same cycle does not raise ready that cycle.
- Arbitration per cycle, with P = FIFO non-empty:
  - sp_valid_i && !P: spec grant.
  - !sp_valid_i && P: retire grant; dequeue the head.
  - sp_valid_i && P && starve<STARVE_MAX: spec grant; starve += 1.
  - sp_valid_i && P && starve==STARVE_MAX: retire grant and dequeue; spec is dropped, sp_drop_o=1 next cycle.
  - Neither pending: no grant.
- Starve counter: clears on any retire grant or when the FIFO is empty. Saturates at STARVE_MAX.
- Outputs: all btb_* outputs are registered.
  - Spec grant at t: btb_sp_we_o=1 at t+1 with the sp_* fields captured.
  - Retire grant at t: btb_rt_we_o=1 at t+1 with head fields.
  - btb_sp_we_o and btb_rt_we_o are never both 1.
  - Data fields hold their last value when the strobe is low.
- Simultaneous enqueue and dequeue: occupancy unchanged; pointers wrap modulo RT_DEPTH. Order is strictly FIFO.

Optional Feature:
- BTB_UPD_PERF_EN. When defined, adds outputs perf_sp_drop_o[31:0] and perf_rt_stall_o[31:0].
  - perf_sp_drop_o counts sp_drop_o pulses.
  - perf_rt_stall_o counts cycles with rt_valid_i && !rt_ready_o.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single retire, idle spec: rt_valid_i=1 at t (pc=64'h1000, dir=1) -> btb_rt_we_o=1 at t+2, btb_rt_brpc_o=64'h1000, btb_rt_brdir_o=1; rt_cnt_o back to 0.
- Spec only: sp_valid_i=1 at t (pc=64'h2004, typ=2'b01, tar=64'h3000) -> btb_sp_we_o=1 at t+1 with same fields; btb_rt_we_o=0.
- Starvation, STARVE_MAX=3: one retire queued, sp_valid_i held high -> 3 cycles of btb_sp_we_o=1, then 1 cycle btb_rt_we_o=1 with sp_drop_o=1, then spec wins again.
- Full FIFO, RT_DEPTH=4: 5 back-to-back retire requests with spec busy -> rt_ready_o=0 after the 4th, 5th not accepted, rt_cnt_o=4; issue order matches enqueue order.
- Reset mid-run with 3 queued entries: assert reset_n=0 -> rt_cnt_o=0, both we=0, rt_ready_o=1; no stale entry is issued after release.
- BTB_UPD_PERF_EN: 2 forced drops plus 5 stalled cycles -> perf_sp_drop_o=2, perf_rt_stall_o=5.
